wb_mem_arbiter: RTL and testbench

Two-master Wishbone B3 arbiter that shares the main RAM slave port between the OR1200 data bus (master 0) and instruction bus (master 1). It grants one master at a time and holds the grant for the whole `cyc` cycle, including incrementing and wrapping bursts (`cti`/`bte`). Arbitration is round-robin, and a watchdog terminates stalled accesses with `err`. The block sits between the CPU master ports and the memory slave, ahead of the address masking applied at the RAM.

---
 rtl/wb_mem_arbiter.sv | 95 +++++++++
 tb/tb_wb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin two-master Wishbone B3 arbiter with cycle-long grant hold and stall watchdog.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [AW-1:0]   wbm0_adr_i,
  input  logic [DW-1:0]   wbm0_dat_i,
  input  logic [DW/8-1:0] wbm0_sel_i,
  input  logic            wbm0_we_i,
  input  logic            wbm0_cyc_i,
  input  logic            wbm0_stb_i,
  input  logic [2:0]      wbm0_cti_i,
  input  logic [1:0]      wbm0_bte_i,
  output logic [DW-1:0]   wbm0_dat_o,
  output logic            wbm0_ack_o,
  output logic            wbm0_err_o,
  output logic            wbm0_rty_o,
  input  logic [AW-1:0]   wbm1_adr_i,
  input  logic [DW-1:0]   wbm1_dat_i,
  input  logic [DW/8-1:0] wbm1_sel_i,
  input  logic            wbm1_we_i,
  input  logic            wbm1_cyc_i,
  input  logic            wbm1_stb_i,
  input  logic [2:0]      wbm1_cti_i,
  input  logic [1:0]      wbm1_bte_i,
  output logic [DW-1:0]   wbm1_dat_o,
  output logic            wbm1_ack_o,
  output logic            wbm1_err_o,
  output logic            wbm1_rty_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic            wbs_we_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i,
  output logic [1:0]      grant_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t        r_state, w_next;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          w_own0, w_own1, w_cyc, w_stb, w_resp, w_to;
  assign w_own0 = r_state == OWN0;
  assign w_own1 = r_state == OWN1;
  assign w_cyc  = (w_own0 & wbm0_cyc_i) | (w_own1 & wbm1_cyc_i);
  assign w_stb  = w_cyc & ((w_own0 & wbm0_stb_i) | (w_own1 & wbm1_stb_i));
  assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_to   = (TIMEOUT != 0) && w_stb && (r_cnt == CW'(TIMEOUT));
  // Re-arbitrate only when the owner has released cyc; the non-last master wins a tie.
  always_comb begin
    w_next = r_state;
    if (!w_cyc)
      w_next = (wbm0_cyc_i & wbm1_cyc_i) ? (r_last ? OWN0 : OWN1) :
               wbm0_cyc_i ? OWN0 : wbm1_cyc_i ? OWN1 : IDLE;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (!w_cyc && w_next != IDLE) r_last <= w_next == OWN1;
      r_cnt   <= (TIMEOUT == 0 || !w_stb || w_resp || w_to) ? '0 : r_cnt + 1'b1;
    end
  end
  assign wbs_adr_o  = w_own0 ? wbm0_adr_i : w_own1 ? wbm1_adr_i : '0;
  assign wbs_dat_o  = w_own0 ? wbm0_dat_i : w_own1 ? wbm1_dat_i : '0;
  assign wbs_sel_o  = w_own0 ? wbm0_sel_i : w_own1 ? wbm1_sel_i : '0;
  assign wbs_we_o   = w_own0 ? wbm0_we_i  : w_own1 ? wbm1_we_i  : 1'b0;
  assign wbs_cti_o  = w_own0 ? wbm0_cti_i : w_own1 ? wbm1_cti_i : '0;
  assign wbs_bte_o  = w_own0 ? wbm0_bte_i : w_own1 ? wbm1_bte_i : '0;
  assign wbs_cyc_o  = w_cyc & ~w_to;
  assign wbs_stb_o  = w_stb & ~w_to;
  // A late slave ack in the timeout cycle is swallowed so the owner sees only err.
  assign wbm0_ack_o = w_own0 & wbs_ack_i & ~w_to;
  assign wbm0_err_o = w_own0 & (wbs_err_i | w_to);
  assign wbm0_rty_o = w_own0 & wbs_rty_i & ~w_to;
  assign wbm1_ack_o = w_own1 & wbs_ack_i & ~w_to;
  assign wbm1_err_o = w_own1 & (wbs_err_i | w_to);
  assign wbm1_rty_o = w_own1 & wbs_rty_i & ~w_to;
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign grant_o    = r_state;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed scenarios checked every cycle against a behavioural arbitration model.
module tb_wb_mem_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] m_adr[2], m_dat[2];
  logic [3:0]  m_sel[2];
  logic [2:0]  m_cti[2];
  logic [1:0]  m_bte[2];
  logic [1:0]  m_we = 2'b01, m_cyc = 2'b00, m_stb = 2'b00;
  logic [31:0] m0_rdat, m1_rdat, s_adr, s_dat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte, grant;
  logic [31:0] slv_dat = 32'hDEADBEEF;
  logic        s_ack, s_err = 1'b0, s_rty = 1'b0, force_ack = 1'b0;
  int          slv_lat = 0, slv_wait = 0;
  int          checks = 0, errors = 0;
  int          own = -1, last = 1, wd = 0;
  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_sel_i(m_sel[0]), .wbm0_we_i(m_we[0]),
    .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]), .wbm0_cti_i(m_cti[0]), .wbm0_bte_i(m_bte[0]),
    .wbm0_dat_o(m0_rdat), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err), .wbm0_rty_o(m0_rty),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_sel_i(m_sel[1]), .wbm1_we_i(m_we[1]),
    .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]), .wbm1_cti_i(m_cti[1]), .wbm1_bte_i(m_bte[1]),
    .wbm1_dat_o(m1_rdat), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err), .wbm1_rty_o(m1_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(slv_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant)
  );
  // Slave acks after slv_lat stalled strobe cycles; a negative latency never acks.
  always_comb s_ack = force_ack | (s_stb && slv_lat >= 0 && slv_wait >= slv_lat);
  always @(posedge clk) slv_wait <= (s_stb && !s_ack) ? slv_wait + 1 : 0;
  function automatic int arb(int o, int l, logic [1:0] c);
    if (o >= 0 && c[o]) return o;
    if (c == 2'b11) return l == 1 ? 0 : 1;
    if (c[0]) return 0;
    if (c[1]) return 1;
    return -1;
  endfunction
  function automatic logic stb_now();
    return own >= 0 && m_cyc[own] && m_stb[own];
  endfunction
  function automatic logic to_now();
    return TO != 0 && stb_now() && wd == TO;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own  <= -1;
      last <= 1;
      wd   <= 0;
    end else begin
      own  <= arb(own, last, m_cyc);
      if (arb(own, last, m_cyc) >= 0 && arb(own, last, m_cyc) != own) last <= arb(own, last, m_cyc);
      wd   <= (stb_now() && !(s_ack || s_err || s_rty) && !to_now()) ? wd + 1 : 0;
    end
  end
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cmp();
    int o;
    logic cy, st, t;
    o  = own;
    cy = o >= 0 && m_cyc[o];
    st = cy && m_stb[o];
    t  = to_now();
    chk("grant", {62'd0, grant}, o == 0 ? 64'd1 : o == 1 ? 64'd2 : 64'd0);
    chk("s_cyc", {63'd0, s_cyc}, {63'd0, cy && !t});
    chk("s_stb", {63'd0, s_stb}, {63'd0, st && !t});
    chk("s_adr", {32'd0, s_adr}, o >= 0 ? {32'd0, m_adr[o]} : 64'd0);
    chk("s_dat", {32'd0, s_dat}, o >= 0 ? {32'd0, m_dat[o]} : 64'd0);
    chk("s_sel", {60'd0, s_sel}, o >= 0 ? {60'd0, m_sel[o]} : 64'd0);
    chk("s_we", {63'd0, s_we}, o >= 0 ? {63'd0, m_we[o]} : 64'd0);
    chk("s_cti", {61'd0, s_cti}, o >= 0 ? {61'd0, m_cti[o]} : 64'd0);
    chk("s_bte", {62'd0, s_bte}, o >= 0 ? {62'd0, m_bte[o]} : 64'd0);
    chk("m0_ack", {63'd0, m0_ack}, {63'd0, o == 0 && s_ack && !t});
    chk("m0_err", {63'd0, m0_err}, {63'd0, o == 0 && (s_err || t)});
    chk("m0_rty", {63'd0, m0_rty}, {63'd0, o == 0 && s_rty && !t});
    chk("m1_ack", {63'd0, m1_ack}, {63'd0, o == 1 && s_ack && !t});
    chk("m1_err", {63'd0, m1_err}, {63'd0, o == 1 && (s_err || t)});
    chk("m1_rty", {63'd0, m1_rty}, {63'd0, o == 1 && s_rty && !t});
    chk("m0_dat", {32'd0, m0_rdat}, {32'd0, slv_dat});
    chk("m1_dat", {32'd0, m1_rdat}, {32'd0, slv_dat});
  endtask
  always @(negedge clk) cmp();
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(int i, logic c, logic s, logic [2:0] cti, logic [1:0] bte, logic [31:0] a);
    m_cyc[i] = c;
    m_stb[i] = s;
    m_cti[i] = cti;
    m_bte[i] = bte;
    m_adr[i] = a;
    m_dat[i] = ~a;
  endtask
  task automatic do_reset();
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    m_sel[0] = 4'h3;
    m_sel[1] = 4'hC;
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
    tick();
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_cyc", {63'd0, s_cyc}, 64'd0);
    chk("rst_dat", {32'd0, m0_rdat}, 64'hDEADBEEF);
    tick();
    rst_n = 1'b1;
    slv_lat = 2;
    req(0, 1, 1, 3'b000, 0, 32'h100);
    tick();
    chk("rd_grant", {62'd0, grant}, 64'd1);
    chk("rd_adr", {32'd0, s_adr}, 64'h100);
    tick();
    chk("rd_early_ack", {63'd0, m0_ack}, 64'd0);
    tick();
    chk("rd_ack", {63'd0, m0_ack}, 64'd1);
    chk("rd_data", {32'd0, m0_rdat}, 64'hDEADBEEF);
    chk("rd_m1_ack", {63'd0, m1_ack}, 64'd0);
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("rd_idle", {62'd0, grant}, 64'd0);
    do_reset();
    slv_lat = 0;
    req(0, 1, 1, 0, 0, 32'h10);
    req(1, 1, 1, 0, 0, 32'h20);
    tick();
    chk("tie_m0", {62'd0, grant}, 64'd1);
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("handover", {62'd0, grant}, 64'd2);
    chk("handover_adr", {32'd0, s_adr}, 64'h20);
    req(1, 0, 0, 0, 0, 0);
    tick();
    req(0, 1, 1, 0, 0, 32'h30);
    req(1, 1, 1, 0, 0, 32'h40);
    tick();
    chk("tie2_m0", {62'd0, grant}, 64'd1);
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
    tick();
    req(1, 1, 1, 3'b010, 2'b01, 32'h200);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("burst_grant", {62'd0, grant}, 64'd2);
      chk("burst_m1_ack", {63'd0, m1_ack}, 64'd1);
      chk("burst_m0_ack", {63'd0, m0_ack}, 64'd0);
      chk("burst_adr", {32'd0, s_adr}, 64'h200 + 64'(4 * b));
      if (b == 0) req(0, 1, 1, 0, 0, 32'h300);
      if (b < 3) req(1, 1, 1, b == 2 ? 3'b111 : 3'b010, 2'b01, 32'h200 + 32'(4 * (b + 1)));
      else req(1, 0, 0, 0, 0, 0);
      tick();
    end
    chk("after_burst", {62'd0, grant}, 64'd1);
    chk("after_burst_adr", {32'd0, s_adr}, 64'h300);
    req(0, 0, 0, 0, 0, 0);
    tick();
    req(0, 1, 0, 0, 0, 32'h400);
    tick();
    chk("lock_grant", {62'd0, grant}, 64'd1);
    req(1, 1, 1, 0, 0, 32'h500);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("lock_hold", {62'd0, grant}, 64'd1);
      chk("lock_no_err", {63'd0, m0_err}, 64'd0);
    end
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("lock_release", {62'd0, grant}, 64'd2);
    chk("lock_m1_ack", {63'd0, m1_ack}, 64'd1);
    req(1, 0, 0, 0, 0, 0);
    tick();
    slv_lat = -1;
    req(0, 1, 1, 0, 0, 32'h600);
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) req(1, 1, 1, 0, 0, 32'h700);
      if (c == 5) begin
        force_ack = 1'b1;
        #1;
      end
      chk("wd_err", {63'd0, m0_err}, {63'd0, c == 5});
      chk("wd_stb", {63'd0, s_stb}, {63'd0, c != 5});
      chk("wd_ack", {63'd0, m0_ack}, 64'd0);
      if (c < 5) tick();
    end
    force_ack = 1'b0;
    slv_lat = 0;
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("wd_next", {62'd0, grant}, 64'd2);
    chk("wd_next_ack", {63'd0, m1_ack}, 64'd1);
    req(1, 0, 0, 0, 0, 0);
    tick();
    req(1, 1, 1, 3'b010, 2'b01, 32'h800);
    tick();
    req(1, 1, 1, 3'b010, 2'b01, 32'h804);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", {62'd0, grant}, 64'd0);
    chk("arst_cyc", {63'd0, s_cyc}, 64'd0);
    chk("arst_stb", {63'd0, s_stb}, 64'd0);
    chk("arst_adr", {32'd0, s_adr}, 64'd0);
    chk("arst_ack", {63'd0, m1_ack}, 64'd0);
    req(0, 1, 1, 0, 0, 32'h900);
    tick();
    chk("arst_hold", {62'd0, grant}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_tie_m0", {62'd0, grant}, 64'd1);
    chk("arst_tie_adr", {32'd0, s_adr}, 64'h900);
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
